// File: rtl/bnn_pe_pkg.sv
// Shared types and constants for the binary-network processing elements.
// The default word/window sizes are also used by the activation line buffer.
package bnn_pe_pkg;

  localparam int PE_WORD_W    = 9;
  localparam int PE_MAX_BEATS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pe_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count built as a balanced recursive adder tree.
// The count width is just wide enough to hold WIDTH.
module popcount_tree
  import bnn_pe_pkg::*;
#(
  parameter int WIDTH = PE_WORD_W
) (
  input  logic [WIDTH-1:0]          bits,
  output logic [clog2(WIDTH+1)-1:0] count
);

  localparam int OUT_W = clog2(WIDTH + 1);

  if (WIDTH == 1) begin : g_leaf
    assign count = bits;
  end else begin : g_split
    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic [clog2(LO_W+1)-1:0] lo_count;
    logic [clog2(HI_W+1)-1:0] hi_count;

    popcount_tree #(.WIDTH(LO_W)) u_lo (.bits(bits[LO_W-1:0]),     .count(lo_count));
    popcount_tree #(.WIDTH(HI_W)) u_hi (.bits(bits[WIDTH-1:LO_W]), .count(hi_count));

    assign count = OUT_W'(lo_count) + OUT_W'(hi_count);
  end

endmodule

// File: rtl/xnor_popcount_accum_pe.sv
// Binary-convolution PE: XNOR each activation beat against a stored weight,
// popcount the unmasked bits and accumulate over a window of beats.
module xnor_popcount_accum_pe
  import bnn_pe_pkg::*;
#(
  parameter int WORD_W    = PE_WORD_W,
  parameter int MAX_BEATS = PE_MAX_BEATS,
  parameter int BEAT_W    = 4,
  parameter int ACC_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [BEAT_W:0]   cfg_beats,
  input  logic [ACC_W-1:0]  cfg_thresh,
  input  logic              w_load,
  input  logic [BEAT_W-1:0] w_addr,
  input  logic [WORD_W-1:0] w_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [WORD_W-1:0] in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_count,
  output logic              out_bit,
  output logic              busy,
  output logic              w_err
);

  localparam int PC_W = clog2(WORD_W + 1);
  localparam logic [BEAT_W:0] ONE_N = (BEAT_W+1)'(1);
  localparam logic [BEAT_W:0] MAX_N = (BEAT_W+1)'(MAX_BEATS);

  if ((2 ** ACC_W) <= WORD_W * MAX_BEATS) begin : g_acc_too_narrow
    $error("ACC_W cannot hold WORD_W*MAX_BEATS");
  end
  if ((2 ** BEAT_W) < MAX_BEATS) begin : g_beat_too_narrow
    $error("BEAT_W cannot index MAX_BEATS");
  end

  pe_state_e         state;
  logic [WORD_W-1:0] weights [MAX_BEATS];
  logic [BEAT_W-1:0] idx;
  logic [BEAT_W:0]   n_beats;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  thresh;

  logic              beat_fire;
  logic              accept;
  logic              addr_ok;
  logic              w_ok;
  logic [BEAT_W-1:0] rd_idx;
  logic [WORD_W-1:0] match_bits;
  logic [PC_W-1:0]   pc;
  logic [ACC_W-1:0]  contrib;
  logic [ACC_W-1:0]  sum_acc;
  logic [BEAT_W:0]   idx_next;
  logic [BEAT_W:0]   cfg_n;

  assign in_ready  = (state != HOLD) | out_ready;
  assign busy      = (state != IDLE);
  assign beat_fire = in_valid & in_ready;
  // A beat that coincides with clear is dropped, but it still blocks a weight write.
  assign accept    = beat_fire & ~clear;

  if (MAX_BEATS < (1 << BEAT_W)) begin : g_addr_chk
    assign addr_ok = (w_addr < BEAT_W'(MAX_BEATS));
  end else begin : g_addr_full
    assign addr_ok = 1'b1;
  end

  assign w_ok = w_load & (state == IDLE) & ~beat_fire & addr_ok;

  // Outside ACCUM the incoming beat is always beat 0 of a new window.
  assign rd_idx     = (state == ACCUM) ? idx : '0;
  assign match_bits = ~(in_data ^ weights[rd_idx]) & in_mask;

  popcount_tree #(.WIDTH(WORD_W)) u_popcount (
    .bits  (match_bits),
    .count (pc)
  );

  assign contrib  = ACC_W'(pc);
  assign sum_acc  = acc + contrib;
  assign idx_next = {1'b0, idx} + ONE_N;

  always_comb begin
    cfg_n = cfg_beats;
    if (cfg_beats == '0) begin
      cfg_n = ONE_N;
    end else if (cfg_beats > MAX_N) begin
      cfg_n = MAX_N;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      n_beats   <= ONE_N;
      acc       <= '0;
      thresh    <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_bit   <= 1'b0;
      w_err     <= 1'b0;
      for (int i = 0; i < MAX_BEATS; i++) begin
        weights[i] <= '0;
      end
    end else begin
      if (w_ok) begin
        weights[w_addr] <= w_data;
      end
      if (w_load && !w_ok) begin
        w_err <= 1'b1;
      end

      if (clear) begin
        state     <= IDLE;
        acc       <= '0;
        idx       <= '0;
        out_valid <= 1'b0;
      end else if (accept && state != ACCUM) begin
        n_beats <= cfg_n;
        thresh  <= cfg_thresh;
        acc     <= contrib;
        idx     <= BEAT_W'(1);
        if (cfg_n == ONE_N) begin
          state     <= HOLD;
          out_valid <= 1'b1;
          out_count <= contrib;
          out_bit   <= (contrib >= cfg_thresh);
        end else begin
          state     <= ACCUM;
          out_valid <= 1'b0;
        end
      end else if (state == ACCUM) begin
        if (accept) begin
          acc <= sum_acc;
          idx <= idx_next[BEAT_W-1:0];
          if (idx_next == n_beats) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_count <= sum_acc;
            out_bit   <= (sum_acc >= thresh);
          end
        end
      end else if (state == HOLD && out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xnor_popcount_accum_pe.sv
// Directed and randomized checks of the XNOR-popcount PE against a
// window-level reference model (weights array + per-beat $countones sums).
module tb_xnor_popcount_accum_pe;

  localparam int WORD_W    = 9;
  localparam int MAX_BEATS = 16;
  localparam int BEAT_W    = 4;
  localparam int ACC_W     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear = 1'b0;
  logic [BEAT_W:0]   cfg_beats = '0;
  logic [ACC_W-1:0]  cfg_thresh = '0;
  logic              w_load = 1'b0;
  logic              w_load2 = 1'b0;
  logic [BEAT_W-1:0] w_addr = '0;
  logic [WORD_W-1:0] w_data = '0;
  logic              in_valid = 1'b0;
  logic              in_valid2 = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic [WORD_W-1:0] in_mask = '0;
  logic              out_ready = 1'b0;

  logic              in_ready, out_valid, out_bit, busy, w_err;
  logic [ACC_W-1:0]  out_count;
  logic              in_ready2, out_valid2, out_bit2, busy2, w_err2;
  logic [ACC_W-1:0]  out_count2;

  int checks = 0;
  int failures = 0;

  logic [WORD_W-1:0] wmodel    [MAX_BEATS];
  logic [WORD_W-1:0] beat_data [32];
  logic [WORD_W-1:0] beat_mask [32];

  always #5 clk = ~clk;

  xnor_popcount_accum_pe #(
    .WORD_W(WORD_W), .MAX_BEATS(MAX_BEATS), .BEAT_W(BEAT_W), .ACC_W(ACC_W)
  ) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .cfg_beats(cfg_beats), .cfg_thresh(cfg_thresh),
    .w_load(w_load), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .out_bit(out_bit),
    .busy(busy), .w_err(w_err)
  );

  // Shallower bank so an out-of-range address is expressible on the 4-bit port.
  xnor_popcount_accum_pe #(
    .WORD_W(WORD_W), .MAX_BEATS(12), .BEAT_W(BEAT_W), .ACC_W(ACC_W)
  ) u_dut_small (
    .clk(clk), .rst(rst), .clear(clear), .cfg_beats(cfg_beats), .cfg_thresh(cfg_thresh),
    .w_load(w_load2), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data), .in_mask(in_mask),
    .out_valid(out_valid2), .out_ready(out_ready), .out_count(out_count2), .out_bit(out_bit2),
    .busy(busy2), .w_err(w_err2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int modelCount(input int n);
    int total;
    total = 0;
    for (int i = 0; i < n; i++) begin
      total += $countones(~(beat_data[i] ^ wmodel[i]) & beat_mask[i]);
    end
    return total;
  endfunction

  task automatic loadWeight(input int addr, input logic [WORD_W-1:0] data);
    w_load = 1'b1;
    w_addr = BEAT_W'(addr);
    w_data = data;
    @(negedge clk);
    w_load = 1'b0;
    wmodel[addr] = data;
  endtask

  task automatic applyStimulus(input logic [WORD_W-1:0] data, input logic [WORD_W-1:0] mask);
    in_valid = 1'b1;
    in_data  = data;
    in_mask  = mask;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drainResult(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_drained_valid"}, out_valid, 1'b0);
    checkOutput({tag, "_drained_busy"}, busy, 1'b0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
    checkOutput({tag, "_out_valid"}, out_valid, 1'b0);
    checkOutput({tag, "_out_count"}, out_count, '0);
    checkOutput({tag, "_out_bit"}, out_bit, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_w_err"}, w_err, 1'b0);
  endtask

  // Feeds one window from beat_data/beat_mask; gaps[i] inserts an idle cycle before beat i.
  task automatic runWindow(input string tag, input int n_cfg, input int thr, input logic [31:0] gaps);
    int n;
    int expected;
    n = (n_cfg == 0) ? 1 : ((n_cfg > MAX_BEATS) ? MAX_BEATS : n_cfg);
    expected = modelCount(n);
    cfg_beats  = (BEAT_W+1)'(n_cfg);
    cfg_thresh = ACC_W'(thr);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && gaps[i]) begin
        in_valid = 1'b0;
        in_data  = WORD_W'($urandom);
        @(negedge clk);
      end
      applyStimulus(beat_data[i], beat_mask[i]);
      cfg_beats  = (BEAT_W+1)'($urandom);
      cfg_thresh = ACC_W'($urandom);
    end
    checkOutput({tag, "_valid"}, out_valid, 1'b1);
    checkOutput({tag, "_count"}, out_count, expected);
    checkOutput({tag, "_bit"}, out_bit, (expected >= thr));
    drainResult(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_a, exp_b, thr_a, thr_b;
    logic [WORD_W-1:0] nb0, nm0, nb1, nm1;

    for (int i = 0; i < MAX_BEATS; i++) wmodel[i] = '0;

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single-beat window from the basic example.
    loadWeight(0, 9'h1FF);
    beat_data[0] = 9'h1FF; beat_mask[0] = 9'h1FF;
    runWindow("single", 1, 5, 0);

    // Three-beat window, then the same window with a bubble after beat 1.
    loadWeight(0, 9'h000);
    loadWeight(1, 9'h1FF);
    loadWeight(2, 9'h0F0);
    beat_data[0] = 9'h000; beat_data[1] = 9'h000; beat_data[2] = 9'h0F0;
    for (int i = 0; i < 3; i++) beat_mask[i] = 9'h1FF;
    checkOutput("win3_model", modelCount(3), 18);
    runWindow("win3", 3, 10, 0);
    runWindow("win3_gap", 3, 10, 32'b010);

    // Padding bits are excluded.
    loadWeight(0, 9'h0A5);
    loadWeight(1, 9'h15A);
    beat_data[0] = 9'h0A5; beat_data[1] = 9'h15A;
    beat_mask[0] = 9'h00F; beat_mask[1] = 9'h00F;
    runWindow("pad", 2, 9, 0);

    // Backpressure followed by a same-cycle handoff into the next window.
    for (int i = 0; i < 3; i++) begin
      beat_data[i] = WORD_W'($urandom);
      beat_mask[i] = WORD_W'($urandom);
    end
    exp_a = modelCount(3);
    thr_a = $urandom_range(27, 0);
    cfg_beats = 3; cfg_thresh = ACC_W'(thr_a);
    for (int i = 0; i < 3; i++) applyStimulus(beat_data[i], beat_mask[i]);
    nb0 = WORD_W'($urandom); nm0 = WORD_W'($urandom);
    nb1 = WORD_W'($urandom); nm1 = WORD_W'($urandom);
    in_valid = 1'b1; in_data = nb0; in_mask = nm0; out_ready = 1'b0;
    checkOutput("bp_bit", out_bit, (exp_a >= thr_a));
    repeat (5) begin
      checkOutput("bp_valid", out_valid, 1'b1);
      checkOutput("bp_count", out_count, exp_a);
      checkOutput("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    beat_data[0] = nb0; beat_mask[0] = nm0;
    beat_data[1] = nb1; beat_mask[1] = nm1;
    exp_b = modelCount(2);
    thr_b = $urandom_range(18, 0);
    cfg_beats = 2; cfg_thresh = ACC_W'(thr_b); out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_data = nb1; in_mask = nm1;
    checkOutput("handoff_valid", out_valid, 1'b0);
    checkOutput("handoff_busy", busy, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("handoff_res_valid", out_valid, 1'b1);
    checkOutput("handoff_res_count", out_count, exp_b);
    checkOutput("handoff_res_bit", out_bit, (exp_b >= thr_b));
    drainResult("handoff");

    // Clear after two of four beats; the dropped beat and partial sum must vanish.
    cfg_beats = 4; cfg_thresh = 8'd3;
    applyStimulus(WORD_W'($urandom), 9'h1FF);
    applyStimulus(WORD_W'($urandom), 9'h1FF);
    clear = 1'b1; in_valid = 1'b1; in_data = WORD_W'($urandom);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    checkOutput("clear_busy", busy, 1'b0);
    checkOutput("clear_valid", out_valid, 1'b0);
    @(negedge clk);
    checkOutput("clear_valid_later", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      beat_data[i] = WORD_W'($urandom);
      beat_mask[i] = WORD_W'($urandom);
    end
    runWindow("after_clear", 4, $urandom_range(36, 0), $urandom);

    // Weight write during ACCUM is refused and flagged.
    for (int i = 0; i < 2; i++) begin
      beat_data[i] = WORD_W'($urandom);
      beat_mask[i] = 9'h1FF;
    end
    exp_a = modelCount(2);
    cfg_beats = 2; cfg_thresh = 8'd9;
    applyStimulus(beat_data[0], beat_mask[0]);
    w_load = 1'b1; w_addr = 4'd1; w_data = ~wmodel[1];
    @(negedge clk);
    w_load = 1'b0;
    checkOutput("wld_accum_err", w_err, 1'b1);
    applyStimulus(beat_data[1], beat_mask[1]);
    checkOutput("wld_accum_count", out_count, exp_a);
    drainResult("wld_accum");
    loadWeight(1, WORD_W'($urandom));
    checkOutput("w_err_sticky", w_err, 1'b1);

    // Address range check on the 12-deep instance.
    w_load2 = 1'b1; w_addr = 4'd11; w_data = 9'h155;
    @(negedge clk);
    checkOutput("addr11_err", w_err2, 1'b0);
    w_addr = 4'd12;
    @(negedge clk);
    w_load2 = 1'b0;
    checkOutput("addr12_err", w_err2, 1'b1);
    checkOutput("small_busy", busy2, 1'b0);
    checkOutput("small_out_valid", out_valid2, 1'b0);
    checkOutput("small_in_ready", in_ready2, 1'b1);
    checkOutput("small_count_bit", {out_count2, out_bit2}, '0);

    // Randomized windows, including beats=0 and beats beyond the bank depth.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < MAX_BEATS; i++) loadWeight(i, WORD_W'($urandom));
      for (int i = 0; i < MAX_BEATS; i++) begin
        beat_data[i] = WORD_W'($urandom);
        beat_mask[i] = WORD_W'($urandom);
      end
      runWindow("rand", (k == 0) ? 0 : ((k == 1) ? 20 : $urandom_range(20, 0)),
                $urandom_range(100, 0), $urandom);
    end

    // Reset mid-window: outputs return to reset values and the bank is zeroed.
    cfg_beats = 4; cfg_thresh = 8'd1;
    applyStimulus(WORD_W'($urandom), 9'h1FF);
    applyStimulus(WORD_W'($urandom), 9'h1FF);
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("mid_rst");
    checkOutput("mid_rst_small_err", w_err2, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < MAX_BEATS; i++) wmodel[i] = '0;
    for (int i = 0; i < 3; i++) begin
      beat_data[i] = WORD_W'($urandom);
      beat_mask[i] = 9'h1FF;
    end
    runWindow("post_rst", 3, $urandom_range(27, 0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
